// File: rtl/fused_load_sequencer.sv
// Two-phase load sequencer: streams all weights (layer 1 then layer 2, one
// contiguous address range) and then the IFM into the fused BRAM router.
module fused_load_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] size_IFM,
  input  logic [ADDR_W-1:0] size_Weight_layer_1,
  input  logic [ADDR_W-1:0] size_Weight_layer_2,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_addr_fused,
  output logic [DATA_W-1:0] wr_data_fused,
  output logic              we_fused,
  output logic [1:0]        control_load,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD_W   = 2'd1,
    S_LOAD_IFM = 2'd2,
    S_FINISH   = 2'd3
  } state_t;

  localparam logic [1:0] CTRL_NONE   = 2'd0;
  localparam logic [1:0] CTRL_IFM    = 2'd1;
  localparam logic [1:0] CTRL_WEIGHT = 2'd2;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   size_ifm_q, size_ifm_d;
  logic [ADDR_W-1:0]   w_total_q, w_total_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                beat;
  logic [ADDR_W-1:0]   w_sum;

  assign in_ready = (state_q == S_LOAD_W) || (state_q == S_LOAD_IFM);
  assign beat     = in_valid && in_ready;
  assign w_sum    = size_Weight_layer_1 + size_Weight_layer_2;

  always_comb begin
    state_d    = state_q;
    size_ifm_d = size_ifm_q;
    w_total_d  = w_total_q;
    cnt_d      = cnt_q;
    we_d       = 1'b0;
    ctrl_d     = CTRL_NONE;
    addr_d     = addr_q;
    data_d     = data_q;

    // Every accepted beat is presented to the router one cycle later.
    if (beat) begin
      we_d   = 1'b1;
      ctrl_d = (state_q == S_LOAD_W) ? CTRL_WEIGHT : CTRL_IFM;
      addr_d = cnt_q;
      data_d = in_data;
      cnt_d  = cnt_q + ADDR_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          size_ifm_d = size_IFM;
          w_total_d  = w_sum;
          cnt_d      = '0;
          if (w_sum != '0)         state_d = S_LOAD_W;
          else if (size_IFM != '0) state_d = S_LOAD_IFM;
          else                     state_d = S_FINISH;
        end
      end
      S_LOAD_W: begin
        if (beat && (cnt_q == w_total_q - ADDR_W'(1))) begin
          cnt_d   = '0;
          state_d = (size_ifm_q != '0) ? S_LOAD_IFM : S_FINISH;
        end
      end
      S_LOAD_IFM: begin
        if (beat && (cnt_q == size_ifm_q - ADDR_W'(1))) begin
          cnt_d   = '0;
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      size_ifm_q <= '0;
      w_total_q  <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      ctrl_q     <= CTRL_NONE;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      size_ifm_q <= size_ifm_d;
      w_total_q  <= w_total_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      ctrl_q     <= ctrl_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign wr_addr_fused = addr_q;
  assign wr_data_fused = data_q;
  assign we_fused      = we_q;
  assign control_load  = ctrl_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FINISH);

endmodule
